parameterised_seven_segment_display_controller: RTL and testbench
=================================================================

# parameterised_seven_segment_display_controller

Drives an N-digit multiplexed common-anode seven-segment display from a single binary value. Converts the value to BCD with a sequential double-dabble engine behind a valid/ready handshake, then scans the digits at a programmable refresh rate. It also provides leading-zero blanking, a per-digit decimal-point mask, overflow indication and inter-digit ghost blanking. It sits between application logic (e.g. the classifier result register) and the board's segment/digit pins, and replaces fixed 3-digit, 4-bit-per-digit scanning.

## Interface
- N_DIGITS, 3: number of digits; digit 0 is least significant (rightmost).
- VALUE_WIDTH, 10: width of the binary input value.
- REFRESH_DIVIDER, 100000: clk cycles per digit slot (≥ BLANK_CYCLES+1).
- BLANK_CYCLES, 2: cycles at the start of each slot with all digits off (ghost suppression); 0 disables.
- LZ_BLANK, 1: 1 = blank leading zeros (digit 0 is never blanked).
- clk  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  synchronous reset, active-low.
- value  input  VALUE_WIDTH  unsigned binary value to display.
- dp_mask  input  N_DIGITS  decimal point per digit (1 = lit), captured with value.
- value_valid  input  1  value/dp_mask offered.
- value_ready  output  1  controller idle, can accept.
- display_bits  output  8  {dp, g, f, e, d, c, b, a}, active-low (0 = segment lit).
- digit_enable  output  N_DIGITS  one-hot digit drive, active-high.
- overflow  output  1  displayed value exceeds 10^N_DIGITS − 1.

## Operation
- FSM states: IDLE, CONVERT, COMMIT.
  - IDLE: value_ready = 1. value_valid && value_ready → capture value, dp_mask and overflow = (value > 10^N_DIGITS−1), clear BCD shift register, go to CONVERT.
  - CONVERT: VALUE_WIDTH iterations of double-dabble, one shift per cycle. Before each shift, every BCD nibble ≥ 5 gets +3. The BCD register is 4·N_DIGITS bits wide; bits shifted beyond it are discarded, because overflow already covers that case.
  - COMMIT: one cycle. Copy the BCD nibbles, dp mask and overflow flag to the display registers, then go to IDLE.
- value_valid while not ready is ignored; there is no queueing. Holding valid high across a conversion causes a second accept on the first IDLE cycle.
- The display registers change only in COMMIT. Scanning is never interrupted by a conversion.
- Scan: slot counter 0..REFRESH_DIVIDER−1. On wrap, digit index advances by 1 modulo N_DIGITS (wrap N_DIGITS−1 → 0).
- Per-slot output for current index i:
  - counter < BLANK_CYCLES → digit_enable = 0, display_bits = 8'hFF.
  - overflow → every digit shows dash (g lit), dp off: 8'hBF.
  - Otherwise segment code of nibble i, with dp bit = ~dp_mask[i].
  - Codes g..a: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
- Leading-zero blanking (LZ_BLANK=1): digit i>0 is blank if it and all higher nibbles are zero.
  - Blank digit with dp_mask[i]=0: digit_enable[i]=0, display_bits=8'hFF.
  - Blank digit with dp_mask[i]=1: digit enabled, display_bits=8'h7F (dp only).

## Timing
- While reset_n is low at a clock edge:
  - Outputs: value_ready=0, digit_enable=0, display_bits=8'hFF, overflow=0.
  - State: FSM=IDLE, slot counter=0, index=0, display registers=0, dp=0.
- First edge with reset_n high: value_ready=1, slot 0 begins (counter 0).
- display_bits, digit_enable and overflow are registered: they reflect counter/index/display registers of the previous cycle.
- Accept at edge T: state CONVERT for edges T+1..T+VALUE_WIDTH, COMMIT at T+VALUE_WIDTH+1. Display registers are updated at that same edge, and value_ready=1 again from then.
  - Outputs reflect the new value one cycle later (T+VALUE_WIDTH+2). Accept-to-accept minimum is VALUE_WIDTH+2 cycles.
- Reset asserted mid-conversion: conversion abandoned, display registers cleared, no partial commit.
- A full scan period is N_DIGITS·REFRESH_DIVIDER cycles. Each digit is enabled for REFRESH_DIVIDER−BLANK_CYCLES cycles per period.

## Test plan
Bench parameters: N_DIGITS=3, VALUE_WIDTH=10, REFRESH_DIVIDER=8, BLANK_CYCLES=2.
- Reset: hold reset_n low for 5 cycles, release. Required response:
  - During reset: all outputs at reset values.
  - After release: value_ready=1 one edge later; digit 0 shows 8'hC0; digits 1,2 disabled.
- Accept 123, dp_mask=0. Required response:
  - value_ready low for exactly 11 cycles.
  - Then each slot shows: digit0 B0, digit1 A4, digit2 F9, with one-hot enables 001/010/100.
  - First 2 cycles of every slot: enable 000, display_bits FF.
- Accept 7 (LZ_BLANK=1). Required response: digit0 F8; digits 1,2 enable low and FF. Then accept 45 with dp_mask=3'b110. Required response: digit0 92, digit1 19, digit2 7F (enabled).
- Accept 1000. Required response: overflow=1; all three digits BF. Then accept 999. Required response: overflow=0; digits 90/90/90.
- Hold value_valid high continuously with value=5, then 6 presented during CONVERT. Required response:
  - 6 is ignored while busy.
  - Accept pulses are 12 cycles apart.
  - Scan index advances every 8 cycles uninterrupted.
- Assert reset_n low at cycle 4 of CONVERT for 500. Required response: after release, display shows 0 (digit0 C0), overflow=0, value_ready=1.

Source files
------------

// File: rtl/parameterised_seven_segment_display_controller_if.sv
// Value handshake between application logic and the seven-segment controller.
//   value        : unsigned binary value to display
//   dp_mask      : decimal point per digit (1 = lit), captured together with value
//   value_valid  : value/dp_mask offered by the producer
//   value_ready  : controller idle and able to accept
// master = producer side, slave = controller side.
interface parameterised_seven_segment_display_controller_if #(
    parameter int unsigned N_DIGITS    = 3,
    parameter int unsigned VALUE_WIDTH = 10
);
    logic [VALUE_WIDTH-1:0] value;
    logic [N_DIGITS-1:0]    dp_mask;
    logic                   value_valid;
    logic                   value_ready;

    modport master (
        output value,
        output dp_mask,
        output value_valid,
        input  value_ready
    );

    modport slave (
        input  value,
        input  dp_mask,
        input  value_valid,
        output value_ready
    );
endinterface

// File: rtl/parameterised_seven_segment_display_controller.sv
// N-digit multiplexed common-anode seven-segment display controller.
// A binary value accepted over a valid/ready handshake is converted to BCD by a
// sequential double-dabble engine, then committed to display registers that are
// scanned one digit per slot with leading-zero blanking, per-digit decimal points,
// overflow dashes and ghost-suppression blanking at the start of every slot.
// Ports:
//   clk          : system clock, rising edge
//   reset_n      : synchronous reset, active-low
//   value_if     : value / dp_mask / value_valid / value_ready handshake (slave)
//   display_bits : {dp, g, f, e, d, c, b, a}, active-low
//   digit_enable : one-hot digit drive, active-high
//   overflow     : displayed value exceeds 10^N_DIGITS - 1
module parameterised_seven_segment_display_controller #(
    parameter int unsigned N_DIGITS        = 3,
    parameter int unsigned VALUE_WIDTH     = 10,
    parameter int unsigned REFRESH_DIVIDER = 100000,
    parameter int unsigned BLANK_CYCLES    = 2,
    parameter bit          LZ_BLANK        = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    parameterised_seven_segment_display_controller_if.slave value_if,
    output logic [7:0]          display_bits,
    output logic [N_DIGITS-1:0] digit_enable,
    output logic                overflow
);
    localparam int unsigned BcdW = 4 * N_DIGITS;
    localparam int unsigned CntW = (REFRESH_DIVIDER > 1) ? $clog2(REFRESH_DIVIDER) : 1;
    localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned BitW = $clog2(VALUE_WIDTH + 1);

    function automatic longint unsigned max_display(input int unsigned n);
        longint unsigned p = 1;
        for (int unsigned i = 0; i < n; i++) p = p * 10;
        return p - 1;
    endfunction

    localparam longint unsigned MaxValue = max_display(N_DIGITS);

    // Segment code {g..a}, active-low.
    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    typedef enum logic [1:0] {StIdle, StConvert, StCommit} state_e;

    state_e                 state_q, state_d;
    logic                   ready_q;
    logic [VALUE_WIDTH-1:0] bin_q, bin_d;
    logic [BcdW-1:0]        bcd_q, bcd_d, bcd_adj;
    logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [N_DIGITS-1:0]    dp_q, dp_d;
    logic                   ovf_q, ovf_d;
    logic [BcdW-1:0]        disp_bcd_q, disp_bcd_d;
    logic [N_DIGITS-1:0]    disp_dp_q, disp_dp_d;
    logic                   disp_ovf_q, disp_ovf_d;

    assign value_if.value_ready = ready_q;

    // Conversion FSM: next state and datapath.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        bit_cnt_d  = bit_cnt_q;
        dp_d       = dp_q;
        ovf_d      = ovf_q;
        disp_bcd_d = disp_bcd_q;
        disp_dp_d  = disp_dp_q;
        disp_ovf_d = disp_ovf_q;

        bcd_adj = bcd_q;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end

        unique case (state_q)
            StIdle: begin
                if (ready_q && value_if.value_valid) begin
                    bin_d     = value_if.value;
                    dp_d      = value_if.dp_mask;
                    ovf_d     = 64'(value_if.value) > MaxValue;
                    bcd_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = StConvert;
                end
            end
            StConvert: begin
                // Bits leaving the top nibble are dropped; overflow already flags that case.
                bcd_d     = {bcd_adj[BcdW-2:0], bin_q[VALUE_WIDTH-1]};
                bin_d     = bin_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BitW'(VALUE_WIDTH - 1)) state_d = StCommit;
            end
            StCommit: begin
                disp_bcd_d = bcd_q;
                disp_dp_d  = dp_q;
                disp_ovf_d = ovf_q;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            ready_q    <= 1'b0;
            bin_q      <= '0;
            bcd_q      <= '0;
            bit_cnt_q  <= '0;
            dp_q       <= '0;
            ovf_q      <= 1'b0;
            disp_bcd_q <= '0;
            disp_dp_q  <= '0;
            disp_ovf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= (state_d == StIdle);
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            bit_cnt_q  <= bit_cnt_d;
            dp_q       <= dp_d;
            ovf_q      <= ovf_d;
            disp_bcd_q <= disp_bcd_d;
            disp_dp_q  <= disp_dp_d;
            disp_ovf_q <= disp_ovf_d;
        end
    end

    // Digit scan: slot counter and digit index, never stalled by conversion.
    logic [CntW-1:0] slot_q;
    logic [IdxW-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_q <= '0;
            idx_q  <= '0;
        end else if (slot_q == CntW'(REFRESH_DIVIDER - 1)) begin
            slot_q <= '0;
            idx_q  <= (idx_q == IdxW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            slot_q <= slot_q + 1'b1;
        end
    end

    // lz[i]: digit i and every higher nibble are zero (digit 0 never qualifies).
    logic [N_DIGITS-1:0] lz;
    logic                zero_above;

    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
            zero_above = zero_above & (disp_bcd_q[4*i +: 4] == 4'd0);
            if (i != 0) lz[i] = LZ_BLANK & zero_above;
        end
    end

    logic [3:0]          cur_nib;
    logic [N_DIGITS-1:0] onehot;
    logic [N_DIGITS-1:0] en_d;
    logic [7:0]          bits_d;

    always_comb begin
        cur_nib        = disp_bcd_q[4*int'(idx_q) +: 4];
        onehot         = '0;
        onehot[idx_q]  = 1'b1;
        en_d           = '0;
        bits_d         = 8'hFF;
        if (32'(slot_q) < BLANK_CYCLES) begin
            // Ghost-suppression gap: everything off.
        end else if (disp_ovf_q) begin
            en_d   = onehot;
            bits_d = 8'hBF;
        end else if (lz[idx_q]) begin
            // A blanked digit stays lit only to show its decimal point.
            if (disp_dp_q[idx_q]) begin
                en_d   = onehot;
                bits_d = 8'h7F;
            end
        end else begin
            en_d   = onehot;
            bits_d = {~disp_dp_q[idx_q], seg_code(cur_nib)};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            display_bits <= 8'hFF;
            digit_enable <= '0;
            overflow     <= 1'b0;
        end else begin
            display_bits <= bits_d;
            digit_enable <= en_d;
            overflow     <= disp_ovf_q;
        end
    end
endmodule

// File: tb/tb_parameterised_seven_segment_display_controller.sv
module tb_parameterised_seven_segment_display_controller;
    localparam int unsigned NDigits     = 3;
    localparam int unsigned ValueWidth  = 10;
    localparam int unsigned RefreshDiv  = 8;
    localparam int unsigned BlankCycles = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] display_bits;
    logic [2:0] digit_enable;
    logic       overflow;

    always #5 clk = ~clk;

    parameterised_seven_segment_display_controller_if #(
        .N_DIGITS    (NDigits),
        .VALUE_WIDTH (ValueWidth)
    ) vif ();

    parameterised_seven_segment_display_controller #(
        .N_DIGITS        (NDigits),
        .VALUE_WIDTH     (ValueWidth),
        .REFRESH_DIVIDER (RefreshDiv),
        .BLANK_CYCLES    (BlankCycles),
        .LZ_BLANK        (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .value_if     (vif),
        .display_bits (display_bits),
        .digit_enable (digit_enable),
        .overflow     (overflow)
    );

    int tests = 0;
    int fails = 0;

    // Scan position model: out_cnt/out_idx are what the registered outputs show now.
    int   m_cnt   = 0;
    int   m_idx   = 0;
    int   out_cnt = 0;
    int   out_idx = 0;
    logic out_rst = 1'b1;
    int   cyc     = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset_n) begin
            m_cnt   <= 0;
            m_idx   <= 0;
            out_rst <= 1'b1;
        end else begin
            out_rst <= 1'b0;
            out_cnt <= m_cnt;
            out_idx <= m_idx;
            if (m_cnt == int'(RefreshDiv) - 1) begin
                m_cnt <= 0;
                m_idx <= (m_idx == int'(NDigits) - 1) ? 0 : m_idx + 1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Offer one value and confirm the controller is busy for exactly 11 cycles.
    task automatic send(input string tag, input logic [9:0] v, input logic [2:0] dp);
        bit ok;
        int low;
        @(negedge clk);
        vif.value       = v;
        vif.dp_mask     = dp;
        vif.value_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (vif.value_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            vif.value_valid = 1'b0;
            check({tag, "_accept_timeout"}, 32'd0, 32'd1);
            return;
        end
        @(negedge clk);
        vif.value_valid = 1'b0;
        low = 0;
        while (!vif.value_ready && low < 50) begin
            low++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(low), 32'd11);
    endtask

    // Sample each digit on the first unblanked cycle of its slot.
    task automatic check_scan(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [2:0] lit);
        logic [7:0] eb [3];
        bit         found;
        eb[0] = b0;
        eb[1] = b1;
        eb[2] = b2;
        for (int d = 0; d < 3; d++) begin
            found = 1'b0;
            for (int k = 0; k < 40 && !found; k++) begin
                @(negedge clk);
                if (!out_rst && out_idx == d && out_cnt == int'(BlankCycles)) found = 1'b1;
            end
            if (!found) begin
                check($sformatf("%s_d%0d_timeout", tag, d), 32'd0, 32'd1);
            end else begin
                check($sformatf("%s_d%0d_bits", tag, d), 32'(display_bits), 32'(eb[d]));
                check($sformatf("%s_d%0d_en", tag, d), 32'(digit_enable),
                      lit[d] ? 32'(1 << d) : 32'd0);
            end
        end
    endtask

    // The first two cycles of a slot must be dark.
    task automatic check_blank(input string tag);
        bit found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (!out_rst && out_idx == 1 && out_cnt == 0) found = 1'b1;
        end
        if (!found) begin
            check({tag, "_blank_timeout"}, 32'd0, 32'd1);
        end else begin
            for (int c = 0; c < int'(BlankCycles); c++) begin
                if (c != 0) @(negedge clk);
                check($sformatf("%s_blank%0d_en", tag, c), 32'(digit_enable), 32'd0);
                check($sformatf("%s_blank%0d_bits", tag, c), 32'(display_bits), 32'hFF);
            end
        end
    endtask

    initial begin
        int acc [2];
        int n_acc;
        int bad;
        logic prev_ready;

        reset_n         = 1'b0;
        vif.value       = '0;
        vif.dp_mask     = '0;
        vif.value_valid = 1'b0;

        // Reset
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(vif.value_ready), 32'd0);
        check("rst_en", 32'(digit_enable), 32'd0);
        check("rst_bits", 32'(display_bits), 32'hFF);
        check("rst_ovf", 32'(overflow), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(vif.value_ready), 32'd1);
        check("rel_en", 32'(digit_enable), 32'd0);
        check("rel_bits", 32'(display_bits), 32'hFF);
        check_scan("rel", 8'hC0, 8'hFF, 8'hFF, 3'b001);

        // Basic value and slot blanking
        send("v123", 10'd123, 3'b000);
        check_scan("v123", 8'hB0, 8'hA4, 8'hF9, 3'b111);
        check_blank("v123");

        // Leading-zero blanking, with and without decimal points
        send("v7", 10'd7, 3'b000);
        check_scan("v7", 8'hF8, 8'hFF, 8'hFF, 3'b001);
        send("v45", 10'd45, 3'b110);
        check_scan("v45", 8'h92, 8'h19, 8'h7F, 3'b111);

        // Overflow boundary
        send("v1000", 10'd1000, 3'b000);
        check_scan("v1000", 8'hBF, 8'hBF, 8'hBF, 3'b111);
        check("v1000_ovf", 32'(overflow), 32'd1);
        send("v999", 10'd999, 3'b000);
        check_scan("v999", 8'h90, 8'h90, 8'h90, 3'b111);
        check("v999_ovf", 32'(overflow), 32'd0);

        // valid held high: 6 offered while busy, 9 waiting at the next idle cycle
        @(negedge clk);
        vif.value       = 10'd5;
        vif.dp_mask     = 3'b000;
        vif.value_valid = 1'b1;
        prev_ready      = vif.value_ready;
        n_acc           = 0;
        bad             = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (prev_ready && !vif.value_ready && n_acc < 2) begin
                acc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 2) vif.value_valid = 1'b0;
            end
            if (n_acc == 1) begin
                if (cyc - acc[0] >= 2 && cyc - acc[0] <= 6) vif.value = 10'd6;
                else if (cyc - acc[0] >= 7) vif.value = 10'd9;
            end
            if (!out_rst && digit_enable != 3'b000 &&
                (out_cnt < int'(BlankCycles) || digit_enable != 3'(1 << out_idx))) bad++;
            prev_ready = vif.value_ready;
        end
        check("hold_accepts", 32'(n_acc), 32'd2);
        if (n_acc == 2) check("hold_spacing", 32'(acc[1] - acc[0]), 32'd12);
        check("hold_scan", 32'(bad), 32'd0);
        check_scan("hold", 8'h90, 8'hFF, 8'hFF, 3'b001);

        // Reset during conversion of 500
        @(negedge clk);
        vif.value       = 10'd500;
        vif.value_valid = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_n         = 1'b0;
        vif.value_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_ready", 32'(vif.value_ready), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rel_ready", 32'(vif.value_ready), 32'd1);
        check_scan("mid_rel", 8'hC0, 8'hFF, 8'hFF, 3'b001);
        check("mid_rel_ovf", 32'(overflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end
endmodule
